// File: rtl/force_release_ctrl.sv
// -----------------------------------------------------------------------------
// force_release_ctrl
//
// Multi-channel override controller. Each of NCH channels carries a WIDTH-bit
// value that is either driven normally or forced to a commanded override value.
// It sits between functional sources and their consumers as a debug /
// fault-injection override point.
//
// Each channel has its own release semantics:
//   mode=0 FOLLOW : wire-like. After release the channel tracks drv_val again.
//   mode=1 HOLD   : reg-like. The channel only loads drv_val on drv_we, so after
//                   release it keeps the forced value until the next drv_we.
//
// Optional feature, compile-time macro FORCE_TIMER_EN:
//   defined   - a FORCE with cmd_dur=D>0 keeps the channel forced for exactly
//               D cycles, then it auto-releases (with an evt_rel pulse).
//               cmd_dur=0 forces indefinitely.
//   undefined - no timer registers; cmd_dur is ignored and every force is
//               indefinite.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   drv_val    in   NCH*WIDTH  driven source values, ch k = [k*WIDTH +: WIDTH]
//   drv_we     in   NCH        per-channel write strobe (HOLD channels only)
//   mode       in   NCH        per-channel mode: 0=FOLLOW, 1=HOLD
//   cmd_valid  in   1          command present
//   cmd_ready  out  1          controller can accept a command
//   cmd_op     in   2          00=NOP 01=FORCE 10=RELEASE 11=RELEASE_ALL
//   cmd_ch     in   CH_W       target channel (ignored for RELEASE_ALL)
//   cmd_val    in   WIDTH      force value
//   cmd_dur    in   TMR_W      force duration in cycles, 0 = indefinite
//   out_val    out  NCH*WIDTH  registered channel outputs
//   forced     out  NCH        per-channel forced flag
//   evt_rel    out  NCH        one-cycle pulse when a channel leaves FORCED
//   cmd_err    out  1          one-cycle pulse: accepted FORCE/RELEASE had
//                              cmd_ch >= NCH
// -----------------------------------------------------------------------------
module force_release_ctrl #(
  parameter int unsigned      WIDTH   = 4,
  parameter int unsigned      NCH     = 2,
  parameter int unsigned      TMR_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  // Wide enough to encode every channel index and at least one illegal index,
  // so an out-of-range target can actually be presented and flagged.
  localparam int unsigned     CH_W    = $clog2(NCH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] drv_val,
  input  logic [NCH-1:0]       drv_we,
  input  logic [NCH-1:0]       mode,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CH_W-1:0]      cmd_ch,
  input  logic [WIDTH-1:0]     cmd_val,
  input  logic [TMR_W-1:0]     cmd_dur,
  output logic [NCH*WIDTH-1:0] out_val,
  output logic [NCH-1:0]       forced,
  output logic [NCH-1:0]       evt_rel,
  output logic                 cmd_err
);

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_FORCE   = 2'b01;
  localparam logic [1:0] OP_RELEASE = 2'b10;
  localparam logic [1:0] OP_RELALL  = 2'b11;

  localparam logic [CH_W-1:0] NCH_C = CH_W'(NCH);

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_FORCED = 1'b1
  } ch_state_e;

  // Value a FREE channel loads this edge: FOLLOW always tracks the source,
  // HOLD only takes it on a write strobe.
  function automatic logic [WIDTH-1:0] free_next(
    input logic             hold,
    input logic             we,
    input logic [WIDTH-1:0] drv,
    input logic [WIDTH-1:0] cur
  );
    return (!hold || we) ? drv : cur;
  endfunction

  logic                 r_cmd_ready;
  logic                 r_err;
  logic                 w_err_nxt;
  logic [NCH-1:0]       r_evt;
  logic [NCH-1:0]       w_evt_nxt;
  ch_state_e            r_state     [NCH];
  ch_state_e            w_state_nxt [NCH];
  logic [WIDTH-1:0]     r_out       [NCH];
  logic [WIDTH-1:0]     w_out_nxt   [NCH];
  logic [WIDTH-1:0]     w_drv       [NCH];

  logic                 w_accept;
  logic                 w_ch_ok;
  logic [NCH-1:0]       w_force_hit;
  logic [NCH-1:0]       w_rel_hit;
  logic [NCH-1:0]       w_expire;

  // Per-channel slicing of the flat buses.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_drv[g]                       = drv_val[g*WIDTH +: WIDTH];
    assign out_val[g*WIDTH +: WIDTH]      = r_out[g];
    assign forced[g]                      = (r_state[g] == ST_FORCED);
  end

  assign cmd_ready = r_cmd_ready;
  assign evt_rel   = r_evt;
  assign cmd_err   = r_err;

  // Command decode: one-hot per-channel force / release requests.
  always_comb begin
    w_accept    = cmd_valid & r_cmd_ready;
    w_ch_ok     = (cmd_ch < NCH_C);
    w_err_nxt   = w_accept & ((cmd_op == OP_FORCE) | (cmd_op == OP_RELEASE)) & ~w_ch_ok;
    w_force_hit = '0;
    w_rel_hit   = '0;
    for (int k = 0; k < NCH; k++) begin
      w_force_hit[k] = w_accept & (cmd_op == OP_FORCE) & w_ch_ok &
                       (cmd_ch == CH_W'(k));
      w_rel_hit[k]   = w_accept &
                       (((cmd_op == OP_RELEASE) & w_ch_ok & (cmd_ch == CH_W'(k))) |
                        (cmd_op == OP_RELALL));
    end
  end

`ifdef FORCE_TIMER_EN
  logic [TMR_W-1:0] r_tmr     [NCH];
  logic [TMR_W-1:0] w_tmr_nxt [NCH];

  // A timer loaded with D reaches 1 after D-1 decrements; releasing on that
  // edge keeps the channel forced for exactly D cycles. A timer of 0 means
  // indefinite and never counts.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      w_expire[k]  = (r_state[k] == ST_FORCED) && (r_tmr[k] == TMR_W'(1));
      w_tmr_nxt[k] = r_tmr[k];
      if (w_force_hit[k]) begin
        w_tmr_nxt[k] = cmd_dur;
      end else if (r_state[k] == ST_FORCED) begin
        if (w_rel_hit[k] || w_expire[k]) begin
          w_tmr_nxt[k] = '0;
        end else if (r_tmr[k] != '0) begin
          w_tmr_nxt[k] = r_tmr[k] - TMR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) r_tmr[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) r_tmr[k] <= w_tmr_nxt[k];
    end
  end
`else
  logic w_unused_dur;
  assign w_unused_dur = ^cmd_dur;
  assign w_expire     = '0;
`endif

  // Per-channel FREE/FORCED next-state and next-output logic.
  // A FORCE always wins over a simultaneous release or expiry: the channel
  // stays forced with the new value and no release event is produced.
  always_comb begin
    w_evt_nxt = '0;
    for (int k = 0; k < NCH; k++) begin
      w_state_nxt[k] = r_state[k];
      w_out_nxt[k]   = r_out[k];
      if (r_state[k] == ST_FREE) begin
        if (w_force_hit[k]) begin
          w_state_nxt[k] = ST_FORCED;
          w_out_nxt[k]   = cmd_val;
        end else begin
          w_out_nxt[k]   = free_next(mode[k], drv_we[k], w_drv[k], r_out[k]);
        end
      end else begin
        if (w_force_hit[k]) begin
          w_out_nxt[k]   = cmd_val;
        end else if (w_rel_hit[k] || w_expire[k]) begin
          // The channel is FREE at the release edge, so the current mode and
          // any write strobe in this cycle already apply.
          w_state_nxt[k] = ST_FREE;
          w_evt_nxt[k]   = 1'b1;
          w_out_nxt[k]   = free_next(mode[k], drv_we[k], w_drv[k], r_out[k]);
        end
        // Otherwise drv_we is dropped: writes are not queued while forced.
      end
    end
  end

  // State / output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_ready <= 1'b0;
      r_err       <= 1'b0;
      r_evt       <= '0;
      for (int k = 0; k < NCH; k++) begin
        r_state[k] <= ST_FREE;
        r_out[k]   <= RST_VAL;
      end
    end else begin
      r_cmd_ready <= 1'b1;
      r_err       <= w_err_nxt;
      r_evt       <= w_evt_nxt;
      for (int k = 0; k < NCH; k++) begin
        r_state[k] <= w_state_nxt[k];
        r_out[k]   <= w_out_nxt[k];
      end
    end
  end

endmodule

// File: tb/tb_force_release_ctrl.sv
module tb_force_release_ctrl;

  localparam int WIDTH = 4;
  localparam int NCH   = 2;
  localparam int TMR_W = 8;
`ifdef FORCE_TIMER_EN
  localparam bit TMR_EN = 1'b1;
`else
  localparam bit TMR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       drv_val = '0;
  logic [1:0]       drv_we = '0;
  logic [1:0]       mode = 2'b01;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [1:0]       cmd_ch = '0;
  logic [3:0]       cmd_val = '0;
  logic [7:0]       cmd_dur = '0;
  logic [7:0]       out_val;
  logic [1:0]       forced;
  logic [1:0]       evt_rel;
  logic             cmd_err;

  always #5 clk = ~clk;

  force_release_ctrl #(
    .WIDTH  (WIDTH),
    .NCH    (NCH),
    .TMR_W  (TMR_W),
    .RST_VAL(4'h0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .drv_val  (drv_val),
    .drv_we   (drv_we),
    .mode     (mode),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_ch   (cmd_ch),
    .cmd_val  (cmd_val),
    .cmd_dur  (cmd_dur),
    .out_val  (out_val),
    .forced   (forced),
    .evt_rel  (evt_rel),
    .cmd_err  (cmd_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Each channel is described by what it shows, whether it is
  // forced, and the absolute edge index at which a timed force ends
  // (-1 = never). Updated on every rising edge from the inputs present there.
  // ---------------------------------------------------------------------------
  logic [3:0] m_out      [2];
  logic       m_forced   [2];
  longint     m_deadline [2];
  logic       m_evt      [2];
  logic       m_err   = 1'b0;
  logic       m_ready = 1'b0;
  longint     cyc     = 0;
  logic       acc, fk, rk, ek;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_out[k] = '0; m_forced[k] = 1'b0; m_deadline[k] = -1; m_evt[k] = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_out[k] = '0; m_forced[k] = 1'b0; m_deadline[k] = -1; m_evt[k] = 1'b0;
      end
      m_err   = 1'b0;
      m_ready = 1'b0;
    end else begin
      acc   = cmd_valid && m_ready;
      m_err = acc && (cmd_op == 2'd1 || cmd_op == 2'd2) && (int'(cmd_ch) >= NCH);
      for (int k = 0; k < 2; k++) begin
        fk = acc && (cmd_op == 2'd1) && (int'(cmd_ch) == k);
        rk = acc && (((cmd_op == 2'd2) && (int'(cmd_ch) == k)) || (cmd_op == 2'd3));
        ek = TMR_EN && m_forced[k] && (m_deadline[k] == cyc);
        m_evt[k] = 1'b0;
        if (fk) begin
          m_forced[k]   = 1'b1;
          m_out[k]      = cmd_val;
          m_deadline[k] = (TMR_EN && cmd_dur != 8'd0) ? cyc + longint'(cmd_dur) : -1;
        end else begin
          if (m_forced[k] && (rk || ek)) begin
            m_forced[k] = 1'b0;
            m_evt[k]    = 1'b1;
          end
          if (!m_forced[k] && (!mode[k] || drv_we[k]))
            m_out[k] = drv_val[k*4 +: 4];
        end
      end
      m_ready = 1'b1;
      cyc++;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    cmp("model out_val", 32'(out_val),   32'({m_out[1], m_out[0]}));
    cmp("model forced",  32'(forced),    32'({m_forced[1], m_forced[0]}));
    cmp("model evt_rel", 32'(evt_rel),   32'({m_evt[1], m_evt[0]}));
    cmp("model cmd_err", 32'(cmd_err),   32'(m_err));
    cmp("model ready",   32'(cmd_ready), 32'(m_ready));
  end

  // Advance to just after the next falling edge; inputs change there, well
  // clear of both clock edges.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [1:0] ch,
                     input logic [3:0] v, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_ch = ch; cmd_val = v; cmd_dur = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1 Reset
    tick(); tick();
    cmp("rst out_val", 32'(out_val), 32'h00);
    cmp("rst forced",  32'(forced),  32'h0);
    cmp("rst ready",   32'(cmd_ready), 32'h0);
    rst_n = 1'b1;
    tick();
    cmp("ready after 1 edge", 32'(cmd_ready), 32'h1);

    // 2 Normal drive (ch0 HOLD, ch1 FOLLOW)
    drv_val = 8'h20; tick();
    cmp("follow ch1", 32'(out_val[7:4]), 32'h2);
    drv_val = 8'h25; drv_we = 2'b01; tick();
    cmp("hold we ch0", 32'(out_val[3:0]), 32'h5);
    drv_val = 8'h29; drv_we = 2'b00; tick();
    cmp("hold no we ch0", 32'(out_val[3:0]), 32'h5);

    // 3 Force then release all
    cmd(2'd1, 2'd0, 4'h3, 8'd0); tick();
    cmp("force ch0", 32'(out_val[3:0]), 32'h3);
    cmd(2'd1, 2'd1, 4'h4, 8'd0); tick();
    cmp("force both out", 32'(out_val), 32'h43);
    cmp("force both flag", 32'(forced), 32'h3);
    cmd(2'd3, 2'd0, 4'h0, 8'd0); tick();
    cmp("relall out", 32'(out_val), 32'h23);
    cmp("relall forced", 32'(forced), 32'h0);
    cmp("relall evt", 32'(evt_rel), 32'h3);
    cmd_valid = 1'b0; tick();
    cmp("evt one cycle", 32'(evt_rel), 32'h0);

    // 4 Write during force is discarded
    cmd(2'd1, 2'd0, 4'h3, 8'd0); tick();
    cmd_valid = 1'b0; drv_val = 8'h27; drv_we = 2'b01; tick();
    cmp("we while forced", 32'(out_val[3:0]), 32'h3);
    drv_we = 2'b00; cmd(2'd2, 2'd0, 4'h0, 8'd0); tick();
    cmp("after release hold", 32'(out_val[3:0]), 32'h3);
    cmp("release evt ch0", 32'(evt_rel), 32'h1);
    cmd_valid = 1'b0; drv_we = 2'b01; tick();
    cmp("next we", 32'(out_val[3:0]), 32'h7);
    drv_we = 2'b00;

    // 5 Errors and no-ops
    cmd(2'd1, 2'd2, 4'hf, 8'd0); tick();
    cmp("bad ch err", 32'(cmd_err), 32'h1);
    cmp("bad ch out", 32'(out_val), 32'h27);
    cmp("bad ch forced", 32'(forced), 32'h0);
    cmd(2'd2, 2'd1, 4'h0, 8'd0); tick();
    cmp("release free evt", 32'(evt_rel), 32'h0);
    cmp("err one cycle", 32'(cmd_err), 32'h0);
    cmd_valid = 1'b0; tick();

    // 6 Timed force
`ifdef FORCE_TIMER_EN
    cmd(2'd1, 2'd1, 4'h4, 8'd5); tick();
    cmd_valid = 1'b0;
    cmp("timed forced c1", 32'(forced[1]), 32'h1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      cmp("timed forced window", 32'(forced[1]), 32'h1);
    end
    tick();
    cmp("timed expire forced", 32'(forced[1]), 32'h0);
    cmp("timed expire evt", 32'(evt_rel), 32'h2);
    cmp("timed expire out", 32'(out_val[7:4]), 32'h2);
    cmd(2'd1, 2'd1, 4'h4, 8'd5); tick();
    cmd_valid = 1'b0; tick(); tick();
    cmd(2'd1, 2'd1, 4'h4, 8'd5); tick();
    cmd_valid = 1'b0;
    cmp("reforce no evt", 32'(evt_rel), 32'h0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      cmp("reforce window", 32'(forced[1]), 32'h1);
    end
    tick();
    cmp("reforce expire", 32'(forced[1]), 32'h0);
    cmp("reforce evt", 32'(evt_rel), 32'h2);
`else
    cmd(2'd1, 2'd1, 4'h4, 8'd5); tick();
    cmd_valid = 1'b0;
    repeat (8) tick();
    cmp("dur ignored forced", 32'(forced[1]), 32'h1);
    cmp("dur ignored out", 32'(out_val[7:4]), 32'h4);
    cmd(2'd3, 2'd0, 4'h0, 8'd0); tick();
    cmd_valid = 1'b0;
    cmp("indef release evt", 32'(evt_rel), 32'h2);
`endif
    tick();

    // Randomized traffic, including occasional mid-run resets.
    repeat (3000) begin
      drv_val   = 8'($urandom);
      drv_we    = 2'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_op    = 2'($urandom);
      cmd_ch    = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3))
                                              : 2'($urandom_range(0, 1));
      cmd_val   = 4'($urandom);
      cmd_dur   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      rst_n     = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
